// File: rtl/uart_bus_if.sv
// CPU-side bus of the UART core: TX enqueue and RX dequeue handshakes.
// Master is the CPU side; slave is the UART core.
interface uart_bus_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] w_data;
  logic            wr_uart;
  logic            tx_full;
  logic [DBIT-1:0] r_data;
  logic            rd_uart;
  logic            rx_empty;

  modport master (
    output w_data, wr_uart, rd_uart,
    input  tx_full, r_data, rx_empty
  );

  modport slave (
    input  w_data, wr_uart, rd_uart,
    output tx_full, r_data, rx_empty
  );
endinterface

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: baud tick gen, RX/TX FSMs, FWFT FIFOs
// and sticky parity/framing/overrun flags.
module uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem_q [2**AW];
  logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
  logic         do_push, do_pop;

  always_comb begin
    empty   = (wp_q == rp_q);
    full    = (wp_q[AW] != rp_q[AW]) &&
              (wp_q[AW-1:0] == rp_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wp_d    = wp_q + {{AW{1'b0}}, do_push};
    rp_d    = rp_q + {{AW{1'b0}}, do_pop};
    dout    = empty ? '0 : mem_q[rp_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

module uart_core_param #(
  parameter int DBIT    = 8,
  parameter int PARITY  = 0,
  parameter int SB_TICK = 16,
  parameter int FIFO_AW = 4,
  parameter int DVSR_W  = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              rx,
  output logic              tx,
  uart_bus_if.slave         bus,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err,
  input  logic              clr_err
);
  localparam int NW = $clog2(DBIT);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_e;

  function automatic logic par_of(input logic [DBIT-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  logic [DVSR_W-1:0] cnt_q, cnt_d;
  logic              tick;
  logic [1:0]        sync_q;
  logic              rxs;

  always_comb begin
    tick  = (cnt_q >= dvsr);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    rxs   = sync_q[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      sync_q <= 2'b11;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= {sync_q[0], rx};
    end
  end

  // RX path
  state_e          rx_st_q;
  logic [4:0]      rs_q;
  logic [NW-1:0]   rn_q;
  logic [DBIT-1:0] rb_q;
  logic            rx_last, rx_push, rx_full;
  logic            perr_set, ferr_set, oerr_set;

  always_comb begin
    rx_last  = (rx_st_q == STOP) && tick &&
               (rs_q == 5'(SB_TICK-1));
    rx_push  = rx_last && rxs;
    ferr_set = rx_last && !rxs;
    perr_set = (rx_st_q == PAR) && tick &&
               (rs_q == 5'd15) && (rxs != par_of(rb_q));
    // A pop in the same clock frees a slot, so no overrun then.
    oerr_set = rx_push && rx_full && !bus.rd_uart;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_st_q <= IDLE;
      rs_q    <= '0;
      rn_q    <= '0;
      rb_q    <= '0;
    end else begin
      unique case (rx_st_q)
        IDLE: if (!rxs) begin
          rx_st_q <= START;
          rs_q    <= '0;
        end
        START: if (tick) begin
          if (rs_q == 5'd7) begin
            rs_q    <= '0;
            rn_q    <= '0;
            rx_st_q <= rxs ? IDLE : DATA;
          end else rs_q <= rs_q + 5'd1;
        end
        DATA: if (tick) begin
          if (rs_q == 5'd15) begin
            rs_q <= '0;
            rb_q <= {rxs, rb_q[DBIT-1:1]};
            if (rn_q == NW'(DBIT-1))
              rx_st_q <= (PARITY == 0) ? STOP : PAR;
            else rn_q <= rn_q + 1'b1;
          end else rs_q <= rs_q + 5'd1;
        end
        PAR: if (tick) begin
          if (rs_q == 5'd15) begin
            rs_q    <= '0;
            rx_st_q <= STOP;
          end else rs_q <= rs_q + 5'd1;
        end
        STOP: if (tick) begin
          if (rs_q == 5'(SB_TICK-1)) begin
            rs_q    <= '0;
            rx_st_q <= IDLE;
          end else rs_q <= rs_q + 5'd1;
        end
        default: rx_st_q <= IDLE;
      endcase
    end
  end

  uart_fifo #(.W(DBIT), .AW(FIFO_AW)) u_rx_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (rx_push),
    .pop    (bus.rd_uart),
    .din    (rb_q),
    .dout   (bus.r_data),
    .full   (rx_full),
    .empty  (bus.rx_empty)
  );

  // TX path
  state_e          tx_st_q;
  logic [4:0]      ts_q;
  logic [NW-1:0]   tn_q;
  logic [DBIT-1:0] tb_q, tx_head;
  logic            tp_q, tx_q, tx_empty, tx_pop;

  always_comb begin
    tx_pop = !tx_empty && ((tx_st_q == IDLE) ||
             ((tx_st_q == STOP) && tick &&
              (ts_q == 5'(SB_TICK-1))));
    tx = tx_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_st_q <= IDLE;
      ts_q    <= '0;
      tn_q    <= '0;
      tb_q    <= '0;
      tp_q    <= 1'b0;
      tx_q    <= 1'b1;
    end else if (tx_pop) begin
      tx_st_q <= START;
      ts_q    <= '0;
      tb_q    <= tx_head;
      tp_q    <= par_of(tx_head);
      tx_q    <= 1'b0;
    end else begin
      unique case (tx_st_q)
        IDLE: ;
        START: if (tick) begin
          if (ts_q == 5'd15) begin
            ts_q    <= '0;
            tn_q    <= '0;
            tx_q    <= tb_q[0];
            tx_st_q <= DATA;
          end else ts_q <= ts_q + 5'd1;
        end
        DATA: if (tick) begin
          if (ts_q == 5'd15) begin
            ts_q <= '0;
            tb_q <= tb_q >> 1;
            if (tn_q == NW'(DBIT-1)) begin
              tx_st_q <= (PARITY == 0) ? STOP : PAR;
              tx_q    <= (PARITY == 0) ? 1'b1 : tp_q;
            end else begin
              tn_q <= tn_q + 1'b1;
              tx_q <= tb_q[1];
            end
          end else ts_q <= ts_q + 5'd1;
        end
        PAR: if (tick) begin
          if (ts_q == 5'd15) begin
            ts_q    <= '0;
            tx_q    <= 1'b1;
            tx_st_q <= STOP;
          end else ts_q <= ts_q + 5'd1;
        end
        STOP: if (tick) begin
          if (ts_q == 5'(SB_TICK-1)) begin
            ts_q    <= '0;
            tx_st_q <= IDLE;
          end else ts_q <= ts_q + 5'd1;
        end
        default: tx_st_q <= IDLE;
      endcase
    end
  end

  uart_fifo #(.W(DBIT), .AW(FIFO_AW)) u_tx_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (bus.wr_uart),
    .pop    (tx_pop),
    .din    (bus.w_data),
    .dout   (tx_head),
    .full   (bus.tx_full),
    .empty  (tx_empty)
  );

  // Sticky flags: a set in the same clock beats clr_err.
  logic perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;

  always_comb begin
    perr_d = perr_set | (perr_q & ~clr_err);
    ferr_d = ferr_set | (ferr_q & ~clr_err);
    oerr_d = oerr_set | (oerr_q & ~clr_err);
    parity_err  = perr_q;
    frame_err   = ferr_q;
    overrun_err = oerr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      oerr_q <= oerr_d;
    end
  end
endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: loopback and driven-line frames,
// scoreboarded against queues of expected bytes.
module tb_uart_core_param;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] dvsr = 11'd3;
  logic        loop = 1'b0;
  logic        rx_drv0 = 1'b1, rx_drv1 = 1'b1;
  logic        rx0, tx0, tx1;
  logic        pe0, fe0, oe0, clr0 = 1'b0;
  logic        pe1, fe1, oe1, clr1 = 1'b0;

  always #5 clk = ~clk;

  uart_bus_if #(.DBIT(8)) bus0 ();
  uart_bus_if #(.DBIT(8)) bus1 ();

  assign rx0 = loop ? tx0 : rx_drv0;

  uart_core_param #(
    .DBIT(8), .PARITY(0), .SB_TICK(16),
    .FIFO_AW(2), .DVSR_W(11)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .dvsr(dvsr),
    .rx(rx0), .tx(tx0), .bus(bus0),
    .parity_err(pe0), .frame_err(fe0),
    .overrun_err(oe0), .clr_err(clr0)
  );

  uart_core_param #(
    .DBIT(8), .PARITY(2), .SB_TICK(16),
    .FIFO_AW(2), .DVSR_W(11)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .dvsr(dvsr),
    .rx(rx_drv1), .tx(tx1), .bus(bus1),
    .parity_err(pe1), .frame_err(fe1),
    .overrun_err(oe1), .clr_err(clr1)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] rxq1[$];
  bit         rd_en = 1'b0;
  bit         mon_en = 1'b0;
  logic [7:0] mon_d;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RX reader for dut0: pops and scores every byte it sees.
  initial begin
    bus0.rd_uart = 1'b0;
    forever begin
      @(negedge clk);
      bus0.rd_uart = 1'b0;
      if (rd_en && !bus0.rx_empty) begin
        if (rxq.size() == 0)
          chk("rx_q_nonempty", 32'(rxq.size()), 32'd1);
        else
          chk("rx_data", 32'(bus0.r_data), 32'(rxq.pop_front()));
        bus0.rd_uart = 1'b1;
      end
    end
  end

  // TX line monitor for dut0: decodes 8N1 at 64 clk/bit.
  initial begin
    forever begin
      @(negedge tx0);
      if (mon_en) begin
        repeat (32) @(negedge clk);
        chk("tx_start", 32'(tx0), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (64) @(negedge clk);
          mon_d[i] = tx0;
        end
        repeat (64) @(negedge clk);
        chk("tx_stop", 32'(tx0), 32'd1);
        if (txq.size() == 0)
          chk("tx_q_nonempty", 32'(txq.size()), 32'd1);
        else
          chk("tx_data", 32'(mon_d), 32'(txq.pop_front()));
      end
    end
  end

  task automatic drive_bit(input bit which, input logic v,
                           input int n);
    @(negedge clk);
    if (which) rx_drv1 = v;
    else       rx_drv0 = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d,
                            input bit has_par, input bit pbit,
                            input bit stop_ok);
    drive_bit(which, 1'b0, 64);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i], 64);
    if (has_par) drive_bit(which, pbit, 64);
    if (stop_ok) drive_bit(which, 1'b1, 64);
    else         drive_bit(which, 1'b0, 48);
    drive_bit(which, 1'b1, 32);
  endtask

  task automatic write0(input logic [7:0] d);
    @(negedge clk);
    bus0.w_data  = d;
    bus0.wr_uart = 1'b1;
    @(negedge clk);
    bus0.wr_uart = 1'b0;
  endtask

  task automatic pulse_clr0();
    @(negedge clk);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rxq.size() == 0 && txq.size() == 0) break;
      @(negedge clk);
    end
    chk(tag, 32'(rxq.size() + txq.size()), 32'd0);
  endtask

  initial begin
    bus0.w_data  = '0;
    bus0.wr_uart = 1'b0;
    bus1.w_data  = '0;
    bus1.wr_uart = 1'b0;
    bus1.rd_uart = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_tx_full", 32'(bus0.tx_full), 32'd0);
    chk("rst_rx_empty", 32'(bus0.rx_empty), 32'd1);
    chk("rst_r_data", 32'(bus0.r_data), 32'd0);
    chk("rst_perr", 32'(pe0), 32'd0);
    chk("rst_ferr", 32'(fe0), 32'd0);
    chk("rst_oerr", 32'(oe0), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // T1 loopback
    loop = 1'b1;
    rd_en = 1'b1;
    mon_en = 1'b1;
    txq.push_back(8'hA5); rxq.push_back(8'hA5);
    write0(8'hA5);
    txq.push_back(8'h3C); rxq.push_back(8'h3C);
    write0(8'h3C);
    wait_drain("t1_drain", 3000);
    chk("t1_perr", 32'(pe0), 32'd0);
    chk("t1_ferr", 32'(fe0), 32'd0);
    chk("t1_oerr", 32'(oe0), 32'd0);
    mon_en = 1'b0;
    loop = 1'b0;
    repeat (50) @(negedge clk);

    // T2 even parity, wrong parity bit
    rxq1.push_back(8'h5A);
    send_frame(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 200 && bus1.rx_empty; i++)
      @(negedge clk);
    chk("t2_avail", 32'(bus1.rx_empty), 32'd0);
    chk("t2_data", 32'(bus1.r_data), 32'(rxq1.pop_front()));
    chk("t2_perr", 32'(pe1), 32'd1);
    chk("t2_ferr", 32'(fe1), 32'd0);
    bus1.rd_uart = 1'b1;
    @(negedge clk);
    bus1.rd_uart = 1'b0;
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    @(negedge clk);
    chk("t2_perr_clr", 32'(pe1), 32'd0);
    chk("t2_empty", 32'(bus1.rx_empty), 32'd1);

    // T3 framing error
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    chk("t3_ferr", 32'(fe0), 32'd1);
    chk("t3_empty", 32'(bus0.rx_empty), 32'd1);
    chk("t3_perr", 32'(pe0), 32'd0);
    pulse_clr0();
    chk("t3_ferr_clr", 32'(fe0), 32'd0);

    // T4 overrun
    rd_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) rxq.push_back(8'(k));
      send_frame(1'b0, 8'(k), 1'b0, 1'b0, 1'b1);
    end
    repeat (20) @(negedge clk);
    chk("t4_oerr", 32'(oe0), 32'd1);
    chk("t4_not_empty", 32'(bus0.rx_empty), 32'd0);
    rd_en = 1'b1;
    wait_drain("t4_drain", 200);
    repeat (4) @(negedge clk);
    chk("t4_empty", 32'(bus0.rx_empty), 32'd1);
    pulse_clr0();
    chk("t4_oerr_clr", 32'(oe0), 32'd0);

    // T5 start glitch of 4 ticks
    @(negedge clk);
    rx_drv0 = 1'b0;
    repeat (16) @(negedge clk);
    rx_drv0 = 1'b1;
    repeat (200) @(negedge clk);
    chk("t5_empty", 32'(bus0.rx_empty), 32'd1);
    chk("t5_ferr", 32'(fe0), 32'd0);
    chk("t5_perr", 32'(pe0), 32'd0);
    rxq.push_back(8'h66);
    send_frame(1'b0, 8'h66, 1'b0, 1'b0, 1'b1);
    wait_drain("t5_drain", 300);

    // T6 reset mid-frame, then a TX burst
    loop = 1'b1;
    write0(8'hFF);
    for (int i = 0; i < 20 && tx0; i++) @(negedge clk);
    chk("t6_start", 32'(tx0), 32'd0);
    repeat (288) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_tx", 32'(tx0), 32'd1);
    chk("t6_rst_full", 32'(bus0.tx_full), 32'd0);
    chk("t6_rst_empty", 32'(bus0.rx_empty), 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t6_full", 32'(bus0.tx_full), (i == 5) ? 32'd1 : 32'd0);
      if (i < 5) begin
        txq.push_back(8'h10 + 8'(i));
        rxq.push_back(8'h10 + 8'(i));
      end
      bus0.w_data  = 8'h10 + 8'(i);
      bus0.wr_uart = 1'b1;
    end
    @(negedge clk);
    bus0.wr_uart = 1'b0;
    wait_drain("t6_drain", 6000);
    chk("t6_ferr", 32'(fe0), 32'd0);
    chk("t6_oerr", 32'(oe0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
